// File: rtl/spi_arb_pkg.sv
// Shared types and constants for the spi request arbiter and its helpers.
package spi_arb_pkg;

  // Arbiter life cycle: wait for a request, hold a grant, run a transfer,
  // then spend one dead cycle before the next grant.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_BUSY  = 2'd2,
    ST_GAP   = 2'd3
  } arb_state_t;

  // Width of the saturating watchdog event counter.
  localparam int ERR_CNT_W = 8;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: finds the first set request bit
// after the previous winner, wrapping modulo NUM_REQ.
module rr_pick #(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic               valid,
  output logic [IDX_W-1:0]   idx
);

  logic [IDX_W-1:0] cand;

  // Walk last+1, last+2, ... and keep the first requester found.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = IDX_W'((int'(last) + i) % NUM_REQ);
      if (!valid && req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/spi_req_arbiter.sv
// Round-robin arbiter sharing one spi core between NUM_REQ requesters.
// The owner's start strobe is forwarded to the core, the core's completion
// pulse is routed back to the owner, and a watchdog frees stuck grants.
module spi_req_arbiter
  import spi_arb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int TIMEOUT = 4096,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                 BUS_CLK,
  input  logic                 BUS_RST,
  input  logic [NUM_REQ-1:0]   REQ,
  input  logic [NUM_REQ-1:0]   START,
  output logic [NUM_REQ-1:0]   GNT,
  output logic [IDX_W-1:0]     SEL,
  output logic                 SPI_START,
  input  logic                 SPI_DONE,
  output logic [NUM_REQ-1:0]   DONE,
  output logic                 BUSY,
  output logic                 TIMEOUT_ERR,
  output logic [ERR_CNT_W-1:0] ERR_CNT
);

  // A zero TIMEOUT disables the watchdog but the timer still needs one bit.
  localparam int TMR_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

  arb_state_t       state;
  logic [IDX_W-1:0] last_q;
  logic [TMR_W-1:0] timer;
  logic             pick_valid;
  logic [IDX_W-1:0] pick_idx;
  logic             wd_expired;

  rr_pick #(
    .NUM_REQ(NUM_REQ)
  ) u_pick (
    .req  (REQ),
    .last (last_q),
    .valid(pick_valid),
    .idx  (pick_idx)
  );

  assign wd_expired = (TIMEOUT != 0) && (timer == TMR_LAST);

  // Arbitration FSM; every output is a flop so the slave-side mux and the
  // spi core see glitch-free controls.
  always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
    if (BUS_RST) begin
      state       <= ST_IDLE;
      GNT         <= '0;
      SEL         <= '0;
      SPI_START   <= 1'b0;
      DONE        <= '0;
      BUSY        <= 1'b0;
      TIMEOUT_ERR <= 1'b0;
      ERR_CNT     <= '0;
      last_q      <= IDX_W'(NUM_REQ - 1);
      timer       <= '0;
    end else begin
      SPI_START   <= 1'b0;
      DONE        <= '0;
      TIMEOUT_ERR <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            GNT    <= ONE << pick_idx;
            SEL    <= pick_idx;
            last_q <= pick_idx;
            timer  <= '0;
            BUSY   <= 1'b1;
            state  <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (START[SEL] && REQ[SEL]) begin
            SPI_START <= 1'b1;
            timer     <= '0;
            state     <= ST_BUSY;
          end else if (!REQ[SEL]) begin
            GNT   <= '0;
            state <= ST_GAP;
          end else if (wd_expired) begin
            TIMEOUT_ERR <= 1'b1;
            if (ERR_CNT != '1) ERR_CNT <= ERR_CNT + 1'b1;
            GNT   <= '0;
            state <= ST_GAP;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        ST_BUSY: begin
          if (SPI_DONE) begin
            DONE  <= ONE << SEL;
            GNT   <= '0;
            state <= ST_GAP;
          end else if (wd_expired) begin
            TIMEOUT_ERR <= 1'b1;
            if (ERR_CNT != '1) ERR_CNT <= ERR_CNT + 1'b1;
            GNT   <= '0;
            state <= ST_GAP;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        ST_GAP: begin
          BUSY  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          GNT   <= '0;
          BUSY  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
